// File: rtl/mem_port_arbiter.sv
// Registered arbiter granting the single axi_interface cache port to either the
// i-cache or d-cache, one transaction at a time, with saturating grant counters.
module mem_port_arbiter #(
  parameter bit FAIR  = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      i_addr,
  input  logic             i_strobe,
  output logic             i_ready,
  output logic [31:0]      i_data,
  input  logic [31:0]      d_addr,
  input  logic             d_strobe,
  input  logic             d_rw,
  input  logic [1:0]       d_size,
  input  logic [3:0]       d_sel,
  input  logic [31:0]      d_st_data,
  output logic             d_ready,
  output logic [31:0]      d_data,
  output logic [31:0]      mem_a,
  output logic             mem_access,
  output logic             mem_write,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_sel,
  output logic [31:0]      mem_st_data,
  input  logic             mem_ready,
  input  logic [31:0]      mem_data,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10
  } state_t;

  state_t             state_r;
  logic               last_d_r;
  logic [31:0]        mem_a_r;
  logic               mem_access_r;
  logic               mem_write_r;
  logic [1:0]         mem_size_r;
  logic [3:0]         mem_sel_r;
  logic [31:0]        mem_st_data_r;
  logic [CNT_W-1:0]   i_cnt_r;
  logic [CNT_W-1:0]   d_cnt_r;
  logic               grant_i_s;
  logic               grant_d_s;
  logic               i_done_s;
  logic               d_done_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Grant decision for the IDLE state; a tie goes to the side not served last when FAIR.
  always_comb begin
    grant_i_s = 1'b0;
    if (i_strobe && d_strobe) begin
      if (FAIR == 1'b1) begin
        grant_i_s = last_d_r;
      end else begin
        grant_i_s = 1'b1;
      end
    end else begin
      grant_i_s = i_strobe;
    end
    grant_d_s = d_strobe & ~grant_i_s;
  end

  // Completion is signalled in the mem_ready cycle itself, only for the granted side.
  always_comb begin
    i_done_s = resetn & (state_r == I_BUSY) & mem_ready;
    d_done_s = resetn & (state_r == D_BUSY) & mem_ready;
  end

  // Arbitration state, latched request fields and performance counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= IDLE;
      last_d_r      <= 1'b1;
      mem_a_r       <= 32'h0000_0000;
      mem_access_r  <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_size_r    <= 2'b00;
      mem_sel_r     <= 4'b0000;
      mem_st_data_r <= 32'h0000_0000;
      i_cnt_r       <= {CNT_W{1'b0}};
      d_cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_i_s) begin
            state_r       <= I_BUSY;
            mem_access_r  <= 1'b1;
            mem_a_r       <= i_addr;
            mem_write_r   <= 1'b0;
            mem_size_r    <= 2'b10;
            mem_sel_r     <= 4'b1111;
            mem_st_data_r <= 32'h0000_0000;
          end else if (grant_d_s) begin
            state_r       <= D_BUSY;
            mem_access_r  <= 1'b1;
            mem_a_r       <= d_addr;
            mem_write_r   <= d_rw;
            mem_size_r    <= d_size;
            mem_sel_r     <= d_sel;
            mem_st_data_r <= d_st_data;
          end else begin
            mem_access_r  <= 1'b0;
          end
        end
        I_BUSY: begin
          if (mem_ready) begin
            state_r      <= IDLE;
            mem_access_r <= 1'b0;
            last_d_r     <= 1'b0;
            i_cnt_r      <= sat_inc(i_cnt_r);
          end
        end
        D_BUSY: begin
          if (mem_ready) begin
            state_r      <= IDLE;
            mem_access_r <= 1'b0;
            last_d_r     <= 1'b1;
            d_cnt_r      <= sat_inc(d_cnt_r);
          end
        end
        default: begin
          state_r      <= IDLE;
          mem_access_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_a       = mem_a_r;
  assign mem_access  = mem_access_r;
  assign mem_write   = mem_write_r;
  assign mem_size    = mem_size_r;
  assign mem_sel     = mem_sel_r;
  assign mem_st_data = mem_st_data_r;
  assign i_ready     = i_done_s;
  assign d_ready     = d_done_s;
  assign i_data      = mem_data;
  assign d_data      = mem_data;
  assign i_grant_cnt = i_cnt_r;
  assign d_grant_cnt = d_cnt_r;

  mem_port_arbiter_chk u_chk (
    .clk        (clk),
    .resetn     (resetn),
    .i_ready    (i_ready),
    .d_ready    (d_ready),
    .mem_access (mem_access)
  );

endmodule

// Protocol invariants of the arbiter's completion outputs.
module mem_port_arbiter_chk (
  input logic clk,
  input logic resetn,
  input logic i_ready,
  input logic d_ready,
  input logic mem_access
);

  a_one_ready: assert property (@(posedge clk) disable iff (!resetn) !(i_ready && d_ready));
  a_ready_busy: assert property (@(posedge clk) disable iff (!resetn) (i_ready || d_ready) |-> mem_access);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus on a FAIR=1/CNT_W=32 and a FAIR=0/CNT_W=2 arbiter,
// both compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] i_addr, d_addr, d_st_data, mem_data;
  logic        i_strobe, d_strobe, d_rw, mem_ready;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;

  logic        o0_i_ready, o0_d_ready, o0_mem_access, o0_mem_write;
  logic [31:0] o0_i_data, o0_d_data, o0_mem_a, o0_mem_st_data;
  logic [1:0]  o0_mem_size;
  logic [3:0]  o0_mem_sel;
  logic [31:0] o0_i_cnt, o0_d_cnt;

  logic        o1_i_ready, o1_d_ready, o1_mem_access, o1_mem_write;
  logic [31:0] o1_i_data, o1_d_data, o1_mem_a, o1_mem_st_data;
  logic [1:0]  o1_mem_size;
  logic [3:0]  o1_mem_sel;
  logic [1:0]  o1_i_cnt, o1_d_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FAIR(1'b1), .CNT_W(32)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .i_addr(i_addr), .i_strobe(i_strobe), .i_ready(o0_i_ready), .i_data(o0_i_data),
    .d_addr(d_addr), .d_strobe(d_strobe), .d_rw(d_rw), .d_size(d_size), .d_sel(d_sel),
    .d_st_data(d_st_data), .d_ready(o0_d_ready), .d_data(o0_d_data),
    .mem_a(o0_mem_a), .mem_access(o0_mem_access), .mem_write(o0_mem_write),
    .mem_size(o0_mem_size), .mem_sel(o0_mem_sel), .mem_st_data(o0_mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .i_grant_cnt(o0_i_cnt), .d_grant_cnt(o0_d_cnt)
  );

  mem_port_arbiter #(.FAIR(1'b0), .CNT_W(2)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .i_addr(i_addr), .i_strobe(i_strobe), .i_ready(o1_i_ready), .i_data(o1_i_data),
    .d_addr(d_addr), .d_strobe(d_strobe), .d_rw(d_rw), .d_size(d_size), .d_sel(d_sel),
    .d_st_data(d_st_data), .d_ready(o1_d_ready), .d_data(o1_d_data),
    .mem_a(o1_mem_a), .mem_access(o1_mem_access), .mem_write(o1_mem_write),
    .mem_size(o1_mem_size), .mem_sel(o1_mem_sel), .mem_st_data(o1_mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .i_grant_cnt(o1_i_cnt), .d_grant_cnt(o1_d_cnt)
  );

  // Reference model: who owns the port (0 none, 1 I, 2 D), the granted request,
  // who was served last, and how many transactions each side has completed.
  typedef struct {
    int          owner;
    logic [31:0] a;
    logic        w;
    logic [1:0]  sz;
    logic [3:0]  sel;
    logic [31:0] sd;
    bit          last_was_d;
    longint      ci;
    longint      cd;
  } model_t;

  model_t m[2];
  bit     fair_of[2] = '{1'b1, 1'b0};
  longint cnt_max[2] = '{64'd4294967295, 64'd3};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m[k].owner      = 0;
    m[k].a          = 32'h0;
    m[k].w          = 1'b0;
    m[k].sz         = 2'b00;
    m[k].sel        = 4'h0;
    m[k].sd         = 32'h0;
    m[k].last_was_d = 1'b1;
    m[k].ci         = 0;
    m[k].cd         = 0;
  endtask

  task automatic model_step(input int k);
    int pick;
    if (!resetn) begin
      model_reset(k);
    end else if (m[k].owner == 0) begin
      pick = 0;
      if (i_strobe && d_strobe) pick = (!fair_of[k] || m[k].last_was_d) ? 1 : 2;
      else if (i_strobe) pick = 1;
      else if (d_strobe) pick = 2;
      if (pick == 1) begin
        m[k].owner = 1; m[k].a = i_addr; m[k].w = 1'b0;
        m[k].sz = 2'b10; m[k].sel = 4'hF; m[k].sd = 32'h0;
      end else if (pick == 2) begin
        m[k].owner = 2; m[k].a = d_addr; m[k].w = d_rw;
        m[k].sz = d_size; m[k].sel = d_sel; m[k].sd = d_st_data;
      end
    end else if (mem_ready) begin
      if (m[k].owner == 1) begin
        m[k].ci = (m[k].ci < cnt_max[k]) ? m[k].ci + 1 : m[k].ci;
        m[k].last_was_d = 1'b0;
      end else begin
        m[k].cd = (m[k].cd < cnt_max[k]) ? m[k].cd + 1 : m[k].cd;
        m[k].last_was_d = 1'b1;
      end
      m[k].owner = 0;
    end
  endtask

  task automatic check_dut(input int k, input logic acc, input logic [31:0] a, input logic w,
                           input logic [1:0] sz, input logic [3:0] sel, input logic [31:0] sd,
                           input logic ir, input logic [31:0] idat, input logic dr,
                           input logic [31:0] ddat, input logic [63:0] ci, input logic [63:0] cd);
    string p;
    p = $sformatf("u%0d.", k);
    check_val({p, "mem_access"}, 64'(acc), 64'(m[k].owner != 0));
    if (m[k].owner != 0) begin
      check_val({p, "mem_a"}, 64'(a), 64'(m[k].a));
      check_val({p, "mem_write"}, 64'(w), 64'(m[k].w));
      check_val({p, "mem_size"}, 64'(sz), 64'(m[k].sz));
      check_val({p, "mem_sel"}, 64'(sel), 64'(m[k].sel));
      check_val({p, "mem_st_data"}, 64'(sd), 64'(m[k].sd));
    end
    check_val({p, "i_ready"}, 64'(ir), 64'(resetn && mem_ready && m[k].owner == 1));
    check_val({p, "d_ready"}, 64'(dr), 64'(resetn && mem_ready && m[k].owner == 2));
    check_val({p, "i_data"}, 64'(idat), 64'(mem_data));
    check_val({p, "d_data"}, 64'(ddat), 64'(mem_data));
    check_val({p, "i_grant_cnt"}, ci, 64'(m[k].ci));
    check_val({p, "d_grant_cnt"}, cd, 64'(m[k].cd));
  endtask

  // Inputs are already driven; settle, compare both DUTs, advance the model, move to next cycle.
  task automatic cycle(input bit do_check);
    #1;
    if (do_check) begin
      check_dut(0, o0_mem_access, o0_mem_a, o0_mem_write, o0_mem_size, o0_mem_sel, o0_mem_st_data,
                o0_i_ready, o0_i_data, o0_d_ready, o0_d_data, 64'(o0_i_cnt), 64'(o0_d_cnt));
      check_dut(1, o1_mem_access, o1_mem_a, o1_mem_write, o1_mem_size, o1_mem_sel, o1_mem_st_data,
                o1_i_ready, o1_i_data, o1_d_ready, o1_d_data, 64'(o1_i_cnt), 64'(o1_d_cnt));
    end
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    resetn = 1'b0; i_strobe = 1'b1; d_strobe = 1'b1; mem_ready = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_rw = 1'b0; d_size = 2'b00; d_sel = 4'h0;
    d_st_data = 32'h0; mem_data = 32'h0;
    @(negedge clk);

    // Two reset cycles with both strobes high; the second one sees the reset state.
    cycle(1'b0);
    check_val("rst.mem_a", 64'(o0_mem_a), 64'h0);
    check_val("rst.mem_sel", 64'(o0_mem_sel), 64'h0);
    check_val("rst.mem_size", 64'(o1_mem_size), 64'h0);
    check_val("rst.mem_st_data", 64'(o1_mem_st_data), 64'h0);
    cycle(1'b1);

    // Contention: both sides always pending, mem_ready on the third BUSY cycle.
    resetn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      i_addr    = 32'h1FC0_0000 + 32'(c);
      d_addr    = 32'h8000_1004;
      d_rw      = 1'b1;
      d_size    = 2'b01;
      d_sel     = 4'h3;
      d_st_data = (c % 2 == 0) ? 32'h0000_BEEF : 32'hFFFF_0000;
      mem_ready = (c % 4 == 3);
      mem_data  = 32'h3C08_8000 + 32'(c);
      cycle(1'b1);
    end
    #1;
    check_val("fair.i_cnt", 64'(o0_i_cnt), 64'd2);
    check_val("fair.d_cnt", 64'(o0_d_cnt), 64'd2);
    check_val("prio.i_cnt_sat", 64'(o1_i_cnt), 64'd3);
    check_val("prio.d_cnt", 64'(o1_d_cnt), 64'd0);

    // Random traffic: dropped strobes, stray mem_ready, occasional mid-transaction reset.
    for (int c = 0; c < 3000; c++) begin
      resetn    = ($urandom_range(0, 79) != 0);
      i_strobe  = ($urandom_range(0, 2) != 0);
      d_strobe  = ($urandom_range(0, 2) != 0);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_rw      = 1'($urandom_range(0, 1));
      d_size    = 2'($urandom_range(0, 3));
      d_sel     = 4'($urandom_range(0, 15));
      d_st_data = $urandom;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_data  = $urandom;
      cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
